// File: rtl/pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Purpose:
//   Hazard control for a classic 5-stage MIPS-style pipeline. It detects the
//   load-use hazard between EX and DEC and the HI/LO hazard against an
//   in-flight mult/div. From those and a branch redirect in EX it drives the
//   PC / IF-DEC / DEC-EX pipeline register controls. It also keeps saturating
//   stall and flush cycle counters.
//
// Handshake / timing:
//   There is no valid/ready pair. The control outputs PCWrite, FD_Write,
//   FD_Flush and DE_Bubble are purely combinational from the current inputs
//   and the registered MulDivBusy, so they take effect in the same cycle.
//   The cycle is resolved in this priority order: redirect first, then
//   load-use, then HI/LO, then normal advance.
//
// Ports:
//   Clk              in   single clock, rising edge
//   Rst              in   asynchronous active-low reset
//   Rs_DEC/Rt_DEC    in   source register fields of the DEC instruction
//   RsUsed_DEC       in   DEC instruction reads rs
//   RtUsed_DEC       in   DEC instruction reads rt
//   MemRead_EX       in   EX instruction is a load
//   RegWrite_EX      in   EX instruction writes a GPR
//   RegDst_EX        in   destination GPR of the EX instruction
//   Redirect_EX      in   taken branch / jump / jr resolved in EX
//   MulDivStart_DEC  in   DEC instruction is mult/multu/div/divu
//   HiLoRead_DEC     in   DEC instruction reads HI/LO
//   PCWrite          out  PC load enable
//   FD_Write         out  IF/DEC register load enable
//   FD_Flush         out  IF/DEC register loads a NOP
//   DE_Bubble        out  DEC/EX register loads a bubble
//   MulDivBusy       out  HI/LO owned by an in-flight mult/div (registered)
//   StallCount       out  saturating count of cycles with PCWrite low
//   FlushCount       out  saturating count of cycles with FD_Flush high
//   DbgState         out  FSM state (0 = RUN, 1 = MD_WAIT)
//   DbgMdCnt         out  mult/div occupancy down-counter
//
// MD_LATENCY: mult/div occupancy of HI/LO in cycles, legal range 1..15.
// ----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  Rs_DEC,
    input  logic [4:0]  Rt_DEC,
    input  logic        RsUsed_DEC,
    input  logic        RtUsed_DEC,
    input  logic        MemRead_EX,
    input  logic        RegWrite_EX,
    input  logic [4:0]  RegDst_EX,
    input  logic        Redirect_EX,
    input  logic        MulDivStart_DEC,
    input  logic        HiLoRead_DEC,
    output logic        PCWrite,
    output logic        FD_Write,
    output logic        FD_Flush,
    output logic        DE_Bubble,
    output logic        MulDivBusy,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount,
    output logic        DbgState,
    output logic [3:0]  DbgMdCnt
);

    localparam logic [3:0] LP_MD_LAT = 4'(MD_LATENCY);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_md_cnt;
    logic [3:0]  w_md_cnt_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_lu;
    logic        w_hh;
    logic        w_accept;

    // Load-use: a load in EX writing a non-zero GPR that DEC reads.
    assign w_lu = MemRead_EX & RegWrite_EX & (RegDst_EX != 5'd0) &
                  ((RsUsed_DEC & (Rs_DEC == RegDst_EX)) |
                   (RtUsed_DEC & (Rt_DEC == RegDst_EX)));

    // HI/LO hazard: a new mult/div would also clobber the busy HI/LO.
    assign w_hh = MulDivBusy & (HiLoRead_DEC | MulDivStart_DEC);

    // A mult/div issues only in a cycle that advances normally.
    assign w_accept = MulDivStart_DEC & ~Redirect_EX & ~w_lu & ~w_hh;

    assign MulDivBusy = (r_state == ST_MD_WAIT);
    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
    assign DbgState   = r_state;
    assign DbgMdCnt   = r_md_cnt;

    // Pipeline controls. Reset forces normal advance regardless of inputs.
    always_comb begin
        PCWrite   = 1'b1;
        FD_Write  = 1'b1;
        FD_Flush  = 1'b0;
        DE_Bubble = 1'b0;
        if (Rst) begin
            if (Redirect_EX) begin
                FD_Flush  = 1'b1;
                DE_Bubble = 1'b1;
            end else if (w_lu || w_hh) begin
                PCWrite   = 1'b0;
                FD_Write  = 1'b0;
                DE_Bubble = 1'b1;
            end
        end
    end

    // Next state. A redirect does not touch the countdown: the mult/div is
    // older than the branch and still completes.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    w_state_nxt  = ST_MD_WAIT;
                    w_md_cnt_nxt = LP_MD_LAT;
                end
            end
            ST_MD_WAIT: begin
                // <= 1 also recovers from an illegal zero count.
                if (r_md_cnt <= 4'd1) begin
                    w_state_nxt  = ST_RUN;
                    w_md_cnt_nxt = 4'd0;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_md_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= ST_RUN;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!PCWrite && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (FD_Flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

endmodule
